// File: rtl/grf_wb_arbiter_pkg.sv
// rtl/grf_wb_arbiter_pkg.sv - shared widths, FSM states and source tags for the GRF write-back arbiter
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << REG_W;

    typedef enum logic {
        P_PRI   = 1'b0,
        A_FORCE = 1'b1
    } state_e;

    localparam logic SRC_P = 1'b0;
    localparam logic SRC_A = 1'b1;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// rtl/grf_wb_arbiter_if.sv - request, scoreboard and GRF write-port signals of the write-back arbiter
interface grf_wb_if;
    import wb_pkg::*;

    logic              p_valid;
    logic [REG_W-1:0]  p_wa;
    logic [DATA_W-1:0] p_wd;
    logic [DATA_W-1:0] p_pc;
    logic              p_ready;

    logic              a_issue;
    logic [REG_W-1:0]  a_issue_wa;
    logic              a_valid;
    logic [REG_W-1:0]  a_wa;
    logic [DATA_W-1:0] a_wd;
    logic [DATA_W-1:0] a_pc;
    logic              a_ready;

    logic [NREG-1:0]   busy;
    logic              grf_we;
    logic [REG_W-1:0]  grf_wa;
    logic [DATA_W-1:0] grf_wd;
    logic [DATA_W-1:0] grf_pc;

    modport slave (
        input  p_valid, p_wa, p_wd, p_pc, a_issue, a_issue_wa, a_valid, a_wa, a_wd, a_pc,
        output p_ready, a_ready, busy, grf_we, grf_wa, grf_wd, grf_pc
    );

    modport master (
        output p_valid, p_wa, p_wd, p_pc, a_issue, a_issue_wa, a_valid, a_wa, a_wd, a_pc,
        input  p_ready, a_ready, busy, grf_we, grf_wa, grf_wd, grf_pc
    );

endinterface

// File: rtl/grf_wb_arbiter_scoreboard.sv
// rtl/grf_wb_arbiter_scoreboard.sv - busy vector of registers awaiting an A-unit write; set wins over clear
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    output logic [NREG-1:0]  busy
);

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - arbitrates the single GRF write port between pipeline W stage and A unit
// Optional: WB_TRACE_EN prints every committed GRF write with its source.
module grf_wb_arbiter
    import wb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic     clk,
    input  logic     reset,
    grf_wb_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grf_we_q, grf_we_d;
    logic [REG_W-1:0]   grf_wa_q, grf_wa_d;
    logic [DATA_W-1:0]  grf_wd_q, grf_wd_d;
    logic [DATA_W-1:0]  grf_pc_q, grf_pc_d;
    logic               src_q, src_d;
    logic               p_ready, a_ready, p_xfer, a_xfer;

    always_comb begin
        p_ready = (state_q == P_PRI);
        a_ready = (state_q == A_FORCE) || !bus.p_valid;
        p_xfer  = bus.p_valid && p_ready;
        a_xfer  = bus.a_valid && a_ready;

        cnt_d = cnt_q;
        if (a_xfer)
            cnt_d = '0;
        else if (bus.a_valid && !a_ready && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;

        // Only force while A is actually waiting, so a stale count cannot starve P.
        state_d = state_q;
        case (state_q)
            P_PRI:   if (bus.a_valid && !a_xfer && cnt_d >= WAIT_LIM) state_d = A_FORCE;
            A_FORCE: if (a_xfer || !bus.a_valid)                     state_d = P_PRI;
            default: state_d = P_PRI;
        endcase

        grf_we_d = 1'b0;
        grf_wa_d = grf_wa_q;
        grf_wd_d = grf_wd_q;
        grf_pc_d = grf_pc_q;
        src_d    = src_q;
        if (a_xfer) begin
            grf_we_d = (bus.a_wa != '0);
            grf_wa_d = bus.a_wa;
            grf_wd_d = bus.a_wd;
            grf_pc_d = bus.a_pc;
            src_d    = SRC_A;
        end else if (p_xfer) begin
            grf_we_d = (bus.p_wa != '0);
            grf_wa_d = bus.p_wa;
            grf_wd_d = bus.p_wd;
            grf_pc_d = bus.p_pc;
            src_d    = SRC_P;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= P_PRI;
            cnt_q    <= '0;
            grf_we_q <= 1'b0;
            grf_wa_q <= '0;
            grf_wd_q <= '0;
            grf_pc_q <= '0;
            src_q    <= SRC_P;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grf_we_q <= grf_we_d;
            grf_wa_q <= grf_wa_d;
            grf_wd_q <= grf_wd_d;
            grf_pc_q <= grf_pc_d;
            src_q    <= src_d;
        end
    end

    // The clear lands on the same edge the GRF commits the A result.
    wb_scoreboard u_scoreboard (
        .clk     (clk),
        .rst_n   (reset),
        .set_en  (bus.a_issue && bus.a_issue_wa != '0),
        .set_idx (bus.a_issue_wa),
        .clr_en  (grf_we_q && src_q == SRC_A),
        .clr_idx (grf_wa_q),
        .busy    (bus.busy)
    );

    assign bus.p_ready = p_ready;
    assign bus.a_ready = a_ready;
    assign bus.grf_we  = grf_we_q;
    assign bus.grf_wa  = grf_wa_q;
    assign bus.grf_wd  = grf_wd_q;
    assign bus.grf_pc  = grf_pc_q;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && grf_we_q)
            $display("%s@%h: $%d <= %h", (src_q == SRC_A) ? "A " : "P ", grf_pc_q, grf_wa_q, grf_wd_q);
    end
`else
`endif

endmodule
